// File: rtl/regfile_write_queue.sv
// Write-back queue in front of the register file write port, with optional
// pending-write forwarding for rs/rt (enabled by defining RFWQ_FWD_EN).
module regfile_write_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_addr,
    input  logic [DW-1:0]            in_data,
    output logic                     RegWrite,
    output logic [AW-1:0]            Waddr,
    output logic [DW-1:0]            WB,
    input  logic [AW-1:0]            rs,
    input  logic [AW-1:0]            rt,
    output logic                     fwd1_hit,
    output logic [DW-1:0]            fwd1_data,
    output logic                     fwd2_hit,
    output logic [DW-1:0]            fwd2_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          accept;
    logic          push;
    logic          pop;

    assign in_ready = (count != CW'(DEPTH));
    assign accept   = in_valid && in_ready;
    // $0 is hardwired: the handshake completes but nothing is stored
    assign push     = accept && (in_addr != '0);
    assign pop      = (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= in_addr;
            mem_data[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            RegWrite <= 1'b0;
            Waddr    <= '0;
            WB       <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                Waddr  <= mem_addr[rd_ptr];
                WB     <= mem_data[rd_ptr];
            end
            RegWrite <= pop;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef RFWQ_FWD_EN
    // Scan oldest to newest so the last match (newest) overrides earlier ones
    always_comb begin
        logic [PW-1:0] idx;
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        idx       = rd_ptr;
        if (RegWrite && (rs != '0) && (Waddr == rs)) begin
            fwd1_hit  = 1'b1;
            fwd1_data = WB;
        end
        if (RegWrite && (rt != '0) && (Waddr == rt)) begin
            fwd2_hit  = 1'b1;
            fwd2_data = WB;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count) begin
                if ((rs != '0) && (mem_addr[idx] == rs)) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = mem_data[idx];
                end
                if ((rt != '0) && (mem_addr[idx] == rt)) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = mem_data[idx];
                end
            end
        end
    end
`else
    logic unused_lookup;
    assign unused_lookup = ^{rs, rt};
    assign fwd1_hit  = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_hit  = 1'b0;
    assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_regfile_write_queue.sv
// Randomized self-checking bench for regfile_write_queue against a queue-based
// model; forwarding expectations follow RFWQ_FWD_EN.
module tb_regfile_write_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [AW-1:0]  in_addr;
    logic [DW-1:0]  in_data;
    logic           RegWrite;
    logic [AW-1:0]  Waddr;
    logic [DW-1:0]  WB;
    logic [AW-1:0]  rs;
    logic [AW-1:0]  rt;
    logic           fwd1_hit;
    logic [DW-1:0]  fwd1_data;
    logic           fwd2_hit;
    logic [DW-1:0]  fwd2_data;
    logic [CW-1:0]  count;

    always #5 clk = ~clk;

    regfile_write_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .RegWrite(RegWrite), .Waddr(Waddr), .WB(WB),
        .rs(rs), .rt(rt),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
        .count(count)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    logic          m_rw;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wb;
    int            checks   = 0;
    int            failures = 0;

    function automatic logic [DW:0] m_fwd(input logic [AW-1:0] a);
`ifdef RFWQ_FWD_EN
        if (a == '0) return '0;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].a == a) return {1'b1, q[i].d};
        if (m_rw && (m_wa == a)) return {1'b1, m_wb};
        return '0;
`else
        return (a == a) ? '0 : '0;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        m_rw = 1'b0;
        m_wa = '0;
        m_wb = '0;
    endtask

    // One clock: drive a producer beat, take the edge, advance the model
    task automatic cycle(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic acc;
        ent_t e;
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        acc = v && (q.size() != DEPTH);
        @(posedge clk);
        if (q.size() > 0) begin
            e    = q.pop_front();
            m_rw = 1'b1;
            m_wa = e.a;
            m_wb = e.d;
        end else begin
            m_rw = 1'b0;
        end
        if (acc && (a != '0)) q.push_back(ent_t'({a, d}));
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; rs = '0; rt = '0;
        model_reset();
        #2;
        checks++;
        if (count !== '0 || RegWrite !== 1'b0 || Waddr !== '0 || WB !== '0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_init: count=%0d rw=%b waddr=%0d wb=%h ready=%b, want 0 0 0 0 1",
                     count, RegWrite, Waddr, WB, in_ready);
        end
        @(negedge clk); rst = 1'b1;
        cycle(1'b0, '0, '0);
        cycle(1'b1, 5'd3, 32'h1111_0003);
        cycle(1'b1, 5'd4, 32'h1111_0004);
        cycle(1'b1, 5'd6, 32'h1111_0006);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (count !== '0 || RegWrite !== 1'b0 || Waddr !== '0 || WB !== '0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_midburst: count=%0d rw=%b waddr=%0d wb=%h ready=%b, want 0 0 0 0 1",
                     count, RegWrite, Waddr, WB, in_ready);
        end
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, '0);
            checks++;
            if (RegWrite !== 1'b0 || count !== '0) begin
                failures++;
                $display("FAIL reset_no_pulse: rw=%b count=%0d, want 0 0", RegWrite, count);
            end
        end
    endtask

    task automatic test_single();
        cycle(1'b0, '0, '0);
        cycle(1'b1, 5'd5, 32'hDEAD_BEEF);
        checks++;
        if (count !== CW'(1) || RegWrite !== 1'b0) begin
            failures++;
            $display("FAIL single_edgeN: count=%0d rw=%b, want 1 0", count, RegWrite);
        end
        cycle(1'b0, '0, '0);
        checks++;
        if (RegWrite !== 1'b1 || Waddr !== 5'd5 || WB !== 32'hDEAD_BEEF || count !== '0) begin
            failures++;
            $display("FAIL single_write: rw=%b waddr=%0d wb=%h count=%0d, want 1 5 deadbeef 0",
                     RegWrite, Waddr, WB, count);
        end
        cycle(1'b0, '0, '0);
        checks++;
        if (RegWrite !== 1'b0 || Waddr !== 5'd5 || WB !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL single_hold: rw=%b waddr=%0d wb=%h, want 0 5 deadbeef", RegWrite, Waddr, WB);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_d [6];
        int seen = 0;
        for (int i = 0; i < 6; i++) exp_d[i] = $urandom;
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready: cycle %0d ready=%b, want 1", i, in_ready);
            end
            if (i < 6) cycle(1'b1, AW'(i + 1), exp_d[i]);
            else       cycle(1'b0, '0, '0);
            if (RegWrite === 1'b1) begin
                checks++;
                if (seen >= 6 || Waddr !== AW'(seen + 1) || WB !== exp_d[seen]) begin
                    failures++;
                    $display("FAIL b2b_order: write %0d got addr=%0d data=%h", seen, Waddr, WB);
                end
                seen++;
            end
        end
        checks++;
        if (seen != 6) begin
            failures++;
            $display("FAIL b2b_count: writes=%0d, want 6", seen);
        end
    endtask

    task automatic test_zero_drop();
        cycle(1'b0, '0, '0);
        cycle(1'b0, '0, '0);
        in_valid = 1'b1; in_addr = '0; in_data = 32'h1234;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL zero_ready: ready=%b, want 1", in_ready);
        end
        cycle(1'b1, '0, 32'h1234);
        checks++;
        if (count !== '0) begin
            failures++;
            $display("FAIL zero_count: count=%0d, want 0", count);
        end
        cycle(1'b0, '0, '0);
        checks++;
        if (RegWrite !== 1'b0) begin
            failures++;
            $display("FAIL zero_regwrite: rw=%b, want 0", RegWrite);
        end
    endtask

    task automatic test_forward();
        logic          en;
        logic [DW-1:0] da, db;
`ifdef RFWQ_FWD_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        da = 32'hAAAA_0000 | 32'($urandom_range(0, 255));
        db = 32'hBBBB_0000 | 32'($urandom_range(0, 255));
        cycle(1'b0, '0, '0);
        cycle(1'b0, '0, '0);
        rs = 5'd7; rt = '0;
        in_valid = 1'b1; in_addr = 5'd7; in_data = da;
        #1;
        checks++;
        if (fwd1_hit !== 1'b0) begin
            failures++;
            $display("FAIL fwd_prepush: hit=%b, want 0", fwd1_hit);
        end
        cycle(1'b1, 5'd7, da);
        checks++;
        if (fwd1_hit !== en || fwd1_data !== (en ? da : '0)) begin
            failures++;
            $display("FAIL fwd_first: hit=%b data=%h, want %b %h", fwd1_hit, fwd1_data, en, en ? da : '0);
        end
        cycle(1'b1, 5'd7, db);
        checks++;
        if (fwd1_hit !== en || fwd1_data !== (en ? db : '0) || fwd2_hit !== 1'b0 || fwd2_data !== '0) begin
            failures++;
            $display("FAIL fwd_newest: hit=%b data=%h hit2=%b data2=%h, want %b %h 0 0",
                     fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, en, en ? db : '0);
        end
        cycle(1'b0, '0, '0);
        checks++;
        if (fwd1_hit !== en || fwd1_data !== (en ? db : '0)) begin
            failures++;
            $display("FAIL fwd_outstage: hit=%b data=%h, want %b %h", fwd1_hit, fwd1_data, en, en ? db : '0);
        end
        cycle(1'b0, '0, '0);
        checks++;
        if (fwd1_hit !== 1'b0 || fwd1_data !== '0 || fwd2_hit !== 1'b0) begin
            failures++;
            $display("FAIL fwd_drained: hit=%b data=%h hit2=%b, want 0 0 0", fwd1_hit, fwd1_data, fwd2_hit);
        end
    endtask

    task automatic test_random();
        logic [DW:0] e1, e2;
        for (int n = 0; n < 400; n++) begin
            rs = AW'($urandom_range(0, 7));
            rt = AW'($urandom_range(0, 7));
            cycle(1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)), $urandom);
            e1 = m_fwd(rs);
            e2 = m_fwd(rt);
            checks++;
            if (RegWrite !== m_rw || Waddr !== m_wa || WB !== m_wb) begin
                failures++;
                $display("FAIL rand_port n=%0d: rw=%b waddr=%0d wb=%h, want %b %0d %h",
                         n, RegWrite, Waddr, WB, m_rw, m_wa, m_wb);
            end
            checks++;
            if (count !== CW'(q.size()) || in_ready !== (q.size() != DEPTH)) begin
                failures++;
                $display("FAIL rand_count n=%0d: count=%0d ready=%b, want %0d %b",
                         n, count, in_ready, q.size(), q.size() != DEPTH);
            end
            checks++;
            if ({fwd1_hit, fwd1_data} !== e1 || {fwd2_hit, fwd2_data} !== e2) begin
                failures++;
                $display("FAIL rand_fwd n=%0d rs=%0d rt=%0d: got %b/%h %b/%h, want %b/%h %b/%h",
                         n, rs, rt, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data,
                         e1[DW], e1[DW-1:0], e2[DW], e2[DW-1:0]);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_drop();
        test_forward();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
